// File: rtl/id_alu_issue.sv
`default_nettype none
// ============================================================================
// Module   : id_alu_issue
// Purpose  : Decode RV64I OP / OP-IMM / LUI / AUIPC into ALU op code and
//            operands, held in a registered ID->EX slot with a valid/ready
//            handshake and flush.
// Revision : 1.0  initial release
// ============================================================================
module id_alu_issue #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic            flush,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [3:0]      ex_aluop,
  output logic [XLEN-1:0] ex_op1,
  output logic [XLEN-1:0] ex_op2,
  output logic [4:0]      ex_rd,
  output logic            ex_illegal
);

  // Major opcodes handled by this slot
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // funct7 / funct6 qualifiers
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [5:0] F6_BASE = 6'b000000;
  localparam logic [5:0] F6_ALT  = 6'b010000;

  // ALU op codes: [3:2] = unit (arith, logic, shift, compare)
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1011;
  localparam logic [3:0] ALU_SLT  = 4'b1100;
  localparam logic [3:0] ALU_SLTU = 4'b1110;

  // Instruction fields
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [5:0]      funct6;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] shamt;
  logic            unused_rs1_idx;

  assign opcode = in_inst[6:0];
  assign funct3 = in_inst[14:12];
  assign funct7 = in_inst[31:25];
  assign funct6 = in_inst[31:26];
  assign imm_i  = {{(XLEN-12){in_inst[31]}}, in_inst[31:20]};
  assign imm_u  = {{(XLEN-32){in_inst[31]}}, in_inst[31:12], 12'b0};
  assign shamt  = {{(XLEN-6){1'b0}}, in_inst[25:20]};
  // Register indices are resolved upstream; only the data arrives here.
  assign unused_rs1_idx = ^in_inst[19:15];

  // Decoded values ahead of the slot
  logic [3:0]      dec_aluop;
  logic [XLEN-1:0] dec_op1;
  logic [XLEN-1:0] dec_op2;
  logic [4:0]      dec_rd;
  logic            dec_legal;

  // Combinational decode; illegal encodings collapse to an all-zero payload
  always_comb begin
    dec_aluop = ALU_ADD;
    dec_op1   = '0;
    dec_op2   = '0;
    dec_rd    = '0;
    dec_legal = 1'b0;

    case (opcode)
      OPC_OP: begin
        dec_op1 = in_rs1_data;
        dec_op2 = in_rs2_data;
        case (funct3)
          3'b000: begin
            if (funct7 == F7_BASE) begin
              dec_aluop = ALU_ADD;
              dec_legal = 1'b1;
            end else if (funct7 == F7_ALT) begin
              dec_aluop = ALU_SUB;
              dec_legal = 1'b1;
            end
          end
          3'b101: begin
            if (funct7 == F7_BASE) begin
              dec_aluop = ALU_SRL;
              dec_legal = 1'b1;
            end else if (funct7 == F7_ALT) begin
              dec_aluop = ALU_SRA;
              dec_legal = 1'b1;
            end
          end
          3'b001: begin dec_aluop = ALU_SLL;  dec_legal = (funct7 == F7_BASE); end
          3'b010: begin dec_aluop = ALU_SLT;  dec_legal = (funct7 == F7_BASE); end
          3'b011: begin dec_aluop = ALU_SLTU; dec_legal = (funct7 == F7_BASE); end
          3'b100: begin dec_aluop = ALU_XOR;  dec_legal = (funct7 == F7_BASE); end
          3'b110: begin dec_aluop = ALU_OR;   dec_legal = (funct7 == F7_BASE); end
          default: begin dec_aluop = ALU_AND; dec_legal = (funct7 == F7_BASE); end
        endcase
      end

      OPC_OP_IMM: begin
        dec_op1   = in_rs1_data;
        dec_op2   = imm_i;
        dec_legal = 1'b1;
        case (funct3)
          3'b000: dec_aluop = ALU_ADD;
          3'b010: dec_aluop = ALU_SLT;
          3'b011: dec_aluop = ALU_SLTU;
          3'b100: dec_aluop = ALU_XOR;
          3'b110: dec_aluop = ALU_OR;
          3'b111: dec_aluop = ALU_AND;
          3'b001: begin
            dec_op2   = shamt;
            dec_aluop = ALU_SLL;
            dec_legal = (funct6 == F6_BASE);
          end
          default: begin
            dec_op2 = shamt;
            if (funct6 == F6_BASE) begin
              dec_aluop = ALU_SRL;
            end else if (funct6 == F6_ALT) begin
              dec_aluop = ALU_SRA;
            end else begin
              dec_legal = 1'b0;
            end
          end
        endcase
      end

      OPC_LUI: begin
        dec_op2   = imm_u;
        dec_legal = 1'b1;
      end

      OPC_AUIPC: begin
        dec_op1   = in_pc;
        dec_op2   = imm_u;
        dec_legal = 1'b1;
      end

      default: dec_legal = 1'b0;
    endcase

    if (dec_legal) begin
      dec_rd = in_inst[11:7];
    end else begin
      dec_aluop = ALU_ADD;
      dec_op1   = '0;
      dec_op2   = '0;
    end
  end

  // Handshake: a slot that is empty or being drained can take a new entry
  logic load;
  logic slot_illegal;

  assign in_ready   = !ex_valid || ex_ready;
  assign load       = in_valid && in_ready && !flush;
  assign ex_illegal = slot_illegal && ex_valid;

  // Pipeline slot: reset beats flush, flush beats load, load beats drain
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid     <= 1'b0;
      ex_aluop     <= '0;
      ex_op1       <= '0;
      ex_op2       <= '0;
      ex_rd        <= '0;
      slot_illegal <= 1'b0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (load) begin
      ex_valid     <= 1'b1;
      ex_aluop     <= dec_aluop;
      ex_op1       <= dec_op1;
      ex_op2       <= dec_op2;
      ex_rd        <= dec_rd;
      slot_illegal <= !dec_legal;
    end else if (ex_valid && ex_ready) begin
      ex_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire
